// File: rtl/da2_tx.sv
// -----------------------------------------------------------------------------
// da2_tx : serial transmitter for the Pmod DA2 (two DAC121S101 12-bit DACs).
//
// An update request latches one 16-bit frame per channel, {2'b00, pd, value},
// and shifts both frames out MSB first on DINA/DINB with a shared SCLK/SYNC.
// SCLK is derived from clk: each SCLK half-period is CLK_DIV clk cycles.
// A frame occupies 32*CLK_DIV cycles with SYNC low, followed by a 2*CLK_DIV
// cycle gap with SYNC high; busy covers both (34*CLK_DIV cycles).
//
// Build option:
//   DA2_DUAL_EN  defined   : channel B is transmitted on DINB.
//                undefined : DINB is tied low and valueB is not registered.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active low
//   update  in   request to send (ignored while busy)
//   pd      in   [1:0]  DAC power-down bits
//   valueA  in   [11:0] channel A code
//   valueB  in   [11:0] channel B code
//   SCLK    out  serial clock, idles high; DAC samples on its falling edge
//   SYNC    out  frame sync, active low
//   DINA    out  serial data, channel A
//   DINB    out  serial data, channel B
//   busy    out  high during a frame and its trailing gap
// -----------------------------------------------------------------------------
module da2_tx #(
  parameter int CLK_DIV = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic [1:0]  pd,
  input  logic [11:0] valueA,
  input  logic [11:0] valueB,
  output logic        SCLK,
  output logic        SYNC,
  output logic        DINA,
  output logic        DINB,
  output logic        busy
);

  localparam int CNT_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  logic [15:0]      frame_a;
  logic [15:0]      sh_a;

  logic accept;
  logic sclk_rise;
  logic last_rise;
  logic gap_done;

  assign frame_a = {2'b00, pd, valueA};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = SEND;
      SEND:    if (last_rise) state_nxt = GAP;
      GAP:     if (gap_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes; busy is always low in IDLE, so update alone accepts.
  always_comb begin
    accept    = 1'b0;
    sclk_rise = 1'b0;
    last_rise = 1'b0;
    gap_done  = 1'b0;
    unique case (state)
      IDLE: accept = update;
      SEND: begin
        if (cnt == HALF_TC && !SCLK) begin
          sclk_rise = 1'b1;
          last_rise = (idx == 4'd0);
        end
      end
      GAP:     gap_done = (cnt == GAP_TC);
      default: ;
    endcase
  end

  // Control and pin registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SCLK <= 1'b1;
      SYNC <= 1'b1;
      DINA <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
      idx  <= 4'd0;
    end else if (accept) begin
      SYNC <= 1'b0;
      busy <= 1'b1;
      DINA <= frame_a[15];
      idx  <= 4'd15;
      cnt  <= '0;
    end else if (state == SEND) begin
      if (cnt == HALF_TC) begin
        cnt  <= '0;
        SCLK <= ~SCLK;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Falls leave data alone; each rise presents the next bit or closes the frame.
      if (sclk_rise) begin
        if (last_rise) begin
          SYNC <= 1'b1;
          DINA <= 1'b0;
        end else begin
          idx  <= idx - 4'd1;
          DINA <= sh_a[15];
        end
      end
    end else if (state == GAP) begin
      if (gap_done) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Shift register holds the bits still to be sent after the current one.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_a <= {frame_a[14:0], 1'b0};
    end else if (sclk_rise && !last_rise) begin
      sh_a <= {sh_a[14:0], 1'b0};
    end
  end

`ifdef DA2_DUAL_EN
  logic [15:0] frame_b;
  logic [15:0] sh_b;

  assign frame_b = {2'b00, pd, valueB};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DINB <= 1'b0;
    end else if (accept) begin
      DINB <= frame_b[15];
    end else if (sclk_rise) begin
      DINB <= last_rise ? 1'b0 : sh_b[15];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sh_b <= {frame_b[14:0], 1'b0};
    end else if (sclk_rise && !last_rise) begin
      sh_b <= {sh_b[14:0], 1'b0};
    end
  end
`else
  // Single-channel build: DINB kept for pin compatibility only.
  logic unused_value_b;
  assign unused_value_b = ^valueB;
  assign DINB = 1'b0;
`endif

endmodule

// File: tb/tb_da2_tx.sv
// -----------------------------------------------------------------------------
// tb_da2_tx : self-checking bench for da2_tx.
// A reference model accepts update requests on a "free after N cycles" rule
// and queues the expected frame contents and start cycle; a monitor decodes
// the serial pins independently and compares each decoded frame to the queue.
// -----------------------------------------------------------------------------
module tb_da2_tx;

  localparam int CD       = 5;
  localparam int SEND_LEN = 32 * CD;
  localparam int BUSY_LEN = 34 * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        update = 1'b0;
  logic [1:0]  pd = 2'b00;
  logic [11:0] valueA = 12'h000;
  logic [11:0] valueB = 12'h000;
  logic        SCLK, SYNC, DINA, DINB, busy;

  da2_tx #(.CLK_DIV(CD)) dut (
    .clk    (clk),
    .rst    (rst),
    .update (update),
    .pd     (pd),
    .valueA (valueA),
    .valueB (valueB),
    .SCLK   (SCLK),
    .SYNC   (SYNC),
    .DINA   (DINA),
    .DINB   (DINB),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          start;
    logic [15:0] fa;
    logic [15:0] fb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   next_free = 0;
  int   n_acc     = 0;
  int   n_drop    = 0;
  int   n_done    = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] mk_frame(input logic [1:0] p, input logic [11:0] v);
    return {2'b00, p, v};
  endfunction

  // Reference model: a request is taken when the transmitter is free; it then
  // stays occupied for the whole busy window plus the accepting edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      n_drop += exp_q.size();
      exp_q.delete();
      next_free = 0;
    end else if (update && cyc >= next_free) begin
      e.start = cyc;
      e.fa    = mk_frame(pd, valueA);
`ifdef DA2_DUAL_EN
      e.fb    = mk_frame(pd, valueB);
`else
      e.fb    = 16'h0000;
`endif
      exp_q.push_back(e);
      n_acc++;
      next_free = cyc + BUSY_LEN + 1;
    end
  end

  // Monitor: decode pins on the falling clk edge.
  logic        p_sclk = 1'b1, p_sync = 1'b1, p_dina = 1'b0, p_dinb = 1'b0;
  logic        p_busy = 1'b0, p_rst = 1'b0;
  bit          in_frame = 1'b0;
  int          low_cnt = 0, falls = 0, start_cyc = 0, busy_cnt = 0;
  int          viol_sclk = 0, viol_data = 0;
  logic [15:0] got_a = 16'h0, got_b = 16'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      in_frame = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
      end else if (p_busy) begin
        check("busy_len", busy_cnt, BUSY_LEN);
        busy_cnt = 0;
      end
      if (p_rst) begin
        if (p_sclk && !SCLK && SYNC) viol_sclk++;
        if ((DINA != p_dina || DINB != p_dinb) && !(!p_sclk && SCLK) && (SYNC == p_sync))
          viol_data++;
      end
      if (p_sync && !SYNC) begin
        in_frame  = 1'b1;
        low_cnt   = 0;
        falls     = 0;
        start_cyc = cyc;
        got_a     = 16'h0;
        got_b     = 16'h0;
      end
      if (in_frame && !SYNC) begin
        low_cnt++;
        if (p_sclk && !SCLK) begin
          falls++;
          got_a = {got_a[14:0], DINA};
          got_b = {got_b[14:0], DINB};
        end
      end
      if (in_frame && SYNC) begin
        in_frame = 1'b0;
        n_done++;
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_start_cycle", start_cyc, e.start);
          check("frame_a", got_a, e.fa);
          check("frame_b", got_b, e.fb);
          check("sclk_falls", falls, 16);
          check("sync_low_len", low_cnt, SEND_LEN);
        end
      end
    end
    p_sclk = SCLK;
    p_sync = SYNC;
    p_dina = DINA;
    p_dinb = DINB;
    p_busy = busy;
    p_rst  = rst;
  end

  task automatic check_reset_pins(input string tag);
    check({tag, "_sclk"}, SCLK, 1);
    check({tag, "_sync"}, SYNC, 1);
    check({tag, "_dina"}, DINA, 0);
    check({tag, "_dinb"}, DINB, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic send(input logic [1:0] p, input logic [11:0] a, input logic [11:0] b);
    @(negedge clk);
    pd = p; valueA = a; valueB = b; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, limit %0d", t, limit);
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    int t;

    // Power-on reset
    #1 rst = 1'b0;
    #1 check_reset_pins("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Basic frame
    send(2'b00, 12'hA5C, 12'h3F0);
    wait_idle(400);

    // Power-down bits in both channels
    send(2'b11, 12'hFFF, 12'h0AB);
    wait_idle(400);

    // Inputs change mid-frame; a request while busy is dropped
    send(2'b00, 12'h123, 12'h321);
    repeat (40) @(negedge clk);
    valueA = 12'h456;
    valueB = 12'h654;
    repeat (20) @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    wait_idle(400);

    // Back-to-back: update held for three frames, inputs changing every cycle
    base = n_acc;
    t = 0;
    @(negedge clk);
    update = 1'b1;
    while (n_acc < base + 3 && t < 1000) begin
      @(negedge clk);
      pd = 2'($urandom);
      valueA = 12'($urandom);
      valueB = 12'($urandom);
      t++;
    end
    update = 1'b0;
    if (t >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL back_to_back: %0d frames accepted, 3 required", n_acc - base);
    end
    wait_idle(600);

    // Reset around bit 8 of a frame, then a clean frame
    send(2'b01, 12'h2AA, 12'h155);
    repeat (78) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_pins("abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(2'b10, 12'h7E1, 12'h18E);
    wait_idle(400);

    // Randomised requests, some landing while busy, inputs wiggling throughout
    for (int i = 0; i < 25; i++) begin
      int gap;
      send(2'($urandom), 12'($urandom), 12'($urandom));
      gap = $urandom_range(0, 250);
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        pd = 2'($urandom);
        valueA = 12'($urandom);
        valueB = 12'($urandom);
      end
    end
    wait_idle(1000);

    check("sclk_fall_while_sync_high", viol_sclk, 0);
    check("data_change_off_rise", viol_data, 0);
    check("frames_completed", n_done, n_acc - n_drop);
    check("reset_dropped_frames", n_drop, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/da2_tx.md
Name: da2_tx

Overview:
- SPI-style transmitter for the Pmod DA2, a dual DAC121S101 12-bit DAC.
- This is the output counterpart of the AD1 ADC reader: it drives values out rather than reading them in.
- On an update request it latches one 16-bit frame per channel and shifts both frames out simultaneously on DINA/DINB, sharing SCLK and SYNC.
- Sits between user logic (test boards, signal generators) and the Pmod header. SCLK is generated internally.

Parameters:
- CLK_DIV, 5: system clocks per SCLK half-period. Must be >= 1. At 100 MHz, 5 gives 10 MHz SCLK; the DAC maximum is 30 MHz.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-low reset
- update  in  1  request to send; sampled every clk
- pd  in  2  DAC power-down bits (00 = normal, 01 = 1k to GND, 10 = 100k to GND, 11 = high-Z)
- valueA  in  12  channel A code
- valueB  in  12  channel B code
- SCLK  out  1  serial clock to the DAC; idles high
- SYNC  out  1  frame sync, active low
- DINA  out  1  serial data, channel A
- DINB  out  1  serial data, channel B
- busy  out  1  high while a frame or the post-frame gap is in progress

Behaviour:
- Reset (rst=0, asynchronous): SCLK=1, SYNC=1, DINA=0, DINB=0, busy=0, state=IDLE, counters cleared.
  - Reset mid-frame aborts immediately with the same values; no partial frame is resumed.
- Frame format: frameX = {2'b00, pd, valueX}, sent MSB first (bit 15 first).
  - pd, valueA and valueB are latched on the accepting clk edge. Later input changes do not affect the frame in flight.
- States:
  - IDLE -> SEND: on a clk edge with update=1 and busy=0. On that same edge: SYNC<=0, busy<=1, SCLK stays 1, DINA/DINB<=bit 15 of each frame, bit index<=15, half-period counter<=0.
  - SEND: the counter runs 0..CLK_DIV-1; at terminal count SCLK toggles.
    - On each SCLK fall, data holds; the DAC samples on the falling edge.
    - On each SCLK rise, if bit index > 0, decrement the index and drive the next bit on DINA/DINB on that same edge.
    - On the rise following the 16th fall: SYNC<=1, DINA/DINB<=0, go to GAP.
    - SEND lasts exactly 32*CLK_DIV clk cycles.
  - GAP: SYNC=1, SCLK=1 for 2*CLK_DIV cycles (meets SYNC minimum high time), then IDLE with busy<=0.
- busy is high for exactly 34*CLK_DIV cycles per frame (170 at default).
- update while busy=1: ignored, not queued.
- update held high continuously: the next frame starts on the first edge with busy=0. There are then no IDLE cycles between frames other than that accept edge.
- SYNC never falls while SCLK=0. Data changes only coincident with SCLK rising edges, or with the SYNC falling edge.
- CLK_DIV=1: SCLK toggles every clk; rules unchanged.

Optional Feature:
- Macro DA2_DUAL_EN.
- Defined: both channels active as above.
- Undefined: DINB held 0 at all times and valueB ignored (no register for it). DINA, SYNC, SCLK and busy timing are unchanged. The DINB port remains for pin-compatibility.

Test Plan:
- Reset value check: rst=0 asserted mid-frame (at bit 8) -> same cycle SYNC=1, SCLK=1, DINA=DINB=0, busy=0; after release, update=1 -> a full clean 16-bit frame.
- Basic frame, CLK_DIV=5: valueA=12'hA5C, valueB=12'h3F0, pd=00, update pulse -> 16 SCLK falls. DINA sampled at falls = 0x0A5C, DINB = 0x03F0. SYNC low for exactly 160 clks, busy high for 170 clks.
- Power-down bits: pd=2'b11, valueA=12'hFFF -> DINA frame 0x3FFF; DINB frame carries the same pd bits.
- Input change during frame: change valueA from 12'h123 to 12'h456 after the 4th fall -> frame still 0x0123. An update pulse while busy -> no extra frame; busy falls after 170 cycles.
- Back-to-back: update held high for 3 frames -> 3 frames separated by a SYNC high time of 10 clks plus the 1-clk accept edge. No SCLK fall while SYNC=1.
- Build without DA2_DUAL_EN, valueB=12'hFFF -> DINB constantly 0; DINA frame and timing identical to the dual build.
